// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and default constants for the PC fetch sequencer and its redirect mux.
// The optional misalign trap is enabled by defining PC_FETCH_MISALIGN_TRAP_EN.
package pc_fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;
    localparam logic [31:0] DEFAULT_PC_STEP      = 32'd4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        SEQ    = 2'd0,
        BRANCH = 2'd1,
        JUMP   = 2'd2,
        EXC    = 2'd3
    } redirect_sel_e;

    function automatic logic isMisaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer (master) and the PC register, instruction memory
// and decode stage (slave).
interface pc_fetch_sequencer_if;

    logic [31:0] pc_curr;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exception;

    modport master (
        input  pc_curr, imem_ack, imem_rdata, stall,
        input  branch_taken, branch_target, jump, jump_target, exception,
        output pc_next, imem_req, imem_addr, instr, instr_pc, instr_valid
    );

    modport slave (
        output pc_curr, imem_ack, imem_rdata, stall,
        output branch_taken, branch_target, jump, jump_target, exception,
        input  pc_next, imem_req, imem_addr, instr, instr_pc, instr_valid
    );

endinterface

// File: rtl/pc_fetch_sequencer_redirect_mux.sv
// Resolves pc_next from the selected redirect source.
// With PC_FETCH_MISALIGN_TRAP_EN a misaligned branch/jump target becomes EXC_VECTOR and is flagged.
module pc_redirect_mux
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  redirect_sel_e sel_i,
    input  logic [31:0]   seqPc_i,
    input  logic [31:0]   branchTarget_i,
    input  logic [31:0]   jumpTarget_i,
    output logic [31:0]   pcNext_o
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    ,
    output logic          misalign_o
`endif
);

    logic [31:0] target;

    assign target = (sel_i == JUMP) ? jumpTarget_i : branchTarget_i;

    always_comb begin
        pcNext_o = seqPc_i;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        misalign_o = 1'b0;
`endif
        case (sel_i)
            SEQ: pcNext_o = seqPc_i;
            EXC: pcNext_o = EXC_VECTOR;
            default: begin
`ifdef PC_FETCH_MISALIGN_TRAP_EN
                if (isMisaligned(target)) begin
                    pcNext_o   = EXC_VECTOR;
                    misalign_o = 1'b1;
                end else begin
                    pcNext_o = target;
                end
`else
                pcNext_o = target & 32'hFFFF_FFFC;
`endif
            end
        endcase
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch controller: sequences the PC register, handshakes with instruction memory and hands words to decode.
// Define PC_FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets and expose the misalign pulse.
module pc_fetch_sequencer
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR,
    parameter logic [31:0] PC_STEP      = DEFAULT_PC_STEP
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_fetch_sequencer_if.master bus,
    output logic [1:0]           fsm_state
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    ,
    output logic                 misalign
`endif
);

    fetch_state_e  state_q, state_d;
    logic          excPending_q, excPending_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   instrPc_q, instrPc_d;
    logic          instrValid_q, instrValid_d;
    redirect_sel_e redirectSel;
    logic [31:0]   seqPc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= BOOT;
            excPending_q <= 1'b0;
            instr_q      <= 32'h0;
            instrPc_q    <= 32'h0;
            instrValid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            excPending_q <= excPending_d;
            instr_q      <= instr_d;
            instrPc_q    <= instrPc_d;
            instrValid_q <= instrValid_d;
        end
    end

    // An exception seen while a request is outstanding poisons the returning word.
    always_comb begin
        state_d      = state_q;
        excPending_d = excPending_q;
        instr_d      = instr_q;
        instrPc_d    = instrPc_q;
        instrValid_d = instrValid_q;
        redirectSel  = SEQ;
        seqPc        = bus.pc_curr;
        case (state_q)
            BOOT: begin
                seqPc   = RESET_VECTOR;
                state_d = FETCH;
                if (bus.exception) redirectSel = EXC;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    if (excPending_q || bus.exception) begin
                        redirectSel  = EXC;
                        excPending_d = 1'b0;
                    end else begin
                        instr_d      = bus.imem_rdata;
                        instrPc_d    = bus.pc_curr;
                        instrValid_d = 1'b1;
                        seqPc        = bus.pc_curr + PC_STEP;
                        state_d      = ISSUE;
                    end
                end else if (bus.exception) begin
                    excPending_d = 1'b1;
                end
            end
            ISSUE: begin
                if (bus.exception) begin
                    redirectSel  = EXC;
                    instrValid_d = 1'b0;
                    state_d      = FETCH;
                end else if (!bus.stall) begin
                    instrValid_d = 1'b0;
                    state_d      = FETCH;
                    if (bus.jump)              redirectSel = JUMP;
                    else if (bus.branch_taken) redirectSel = BRANCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic misalignDetect;
    logic misalign_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) misalign_q <= 1'b0;
        else        misalign_q <= misalignDetect;
    end

    assign misalign = misalign_q;
`endif

    pc_redirect_mux #(
        .EXC_VECTOR(EXC_VECTOR)
    ) u_redirect_mux (
        .sel_i          (redirectSel),
        .seqPc_i        (seqPc),
        .branchTarget_i (bus.branch_target),
        .jumpTarget_i   (bus.jump_target),
        .pcNext_o       (bus.pc_next)
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_o     (misalignDetect)
`endif
    );

    assign bus.imem_req    = (state_q == FETCH);
    assign bus.imem_addr   = bus.pc_curr;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instrPc_q;
    assign bus.instr_valid = instrValid_q;
    assign fsm_state       = state_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer with a PC register, memory responder and reference model.
// Build with PC_FETCH_MISALIGN_TRAP_EN defined to exercise the misalign trap.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RST_VEC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC = 32'h0000_0080;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  fsmState;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic        misalign;
    logic        mMisalign;
`endif

    pc_fetch_sequencer_if bus();

    pc_fetch_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .fsm_state (fsmState)
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        ,
        .misalign  (misalign)
`endif
    );

    int          nCompared   = 0;
    int          nMismatched = 0;
    logic        checkEn     = 1'b0;
    logic [31:0] pcReg;
    logic        pcForce     = 1'b0;
    logic [31:0] pcForceVal  = 32'h0;
    int          ackDelay    = 2;
    int          memCnt;
    logic        dataOverrideEn = 1'b0;
    logic [31:0] dataOverride   = 32'h0;
    logic [1:0]  mState;
    logic        mExcPend;
    logic        mValid;
    logic [31:0] mInstr;
    logic [31:0] mInstrPc;

    initial forever #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) pcReg <= 32'h0;
        else        pcReg <= pcForce ? pcForceVal : bus.pc_next;
    end
    assign bus.pc_curr = pcReg;

    function automatic logic [31:0] wordAt(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h2002_0005;
        return {addr[23:0], 8'h13};
    endfunction

    // Memory answers after ackDelay idle request cycles, then restarts the count.
    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        memCnt         = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset || !bus.imem_req) begin
                bus.imem_ack = 1'b0;
                memCnt       = 0;
            end else if (memCnt == ackDelay) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = dataOverrideEn ? dataOverride : wordAt(bus.imem_addr);
                memCnt         = 0;
            end else begin
                bus.imem_ack = 1'b0;
                memCnt       = memCnt + 1;
            end
        end
    end

    function automatic logic [31:0] redirTarget(input logic [31:0] t);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        return (t[1:0] != 2'b00) ? EXC_VEC : t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    function automatic logic redirMisaligned();
        if (bus.jump)         return bus.jump_target[1:0] != 2'b00;
        if (bus.branch_taken) return bus.branch_target[1:0] != 2'b00;
        return 1'b0;
    endfunction
`endif

    // Reference model: 0 = boot, 1 = waiting for memory, 2 = word held for decode.
    function automatic logic [31:0] modelPcNext();
        logic [31:0] r;
        r = bus.pc_curr;
        case (mState)
            2'd0: r = bus.exception ? EXC_VEC : RST_VEC;
            2'd1: if (bus.imem_ack) r = (mExcPend || bus.exception) ? EXC_VEC : bus.pc_curr + 32'd4;
            2'd2: begin
                if (bus.exception) r = EXC_VEC;
                else if (!bus.stall) begin
                    if (bus.jump)              r = redirTarget(bus.jump_target);
                    else if (bus.branch_taken) r = redirTarget(bus.branch_target);
                end
            end
            default: r = RST_VEC;
        endcase
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mState   <= 2'd0;
            mExcPend <= 1'b0;
            mValid   <= 1'b0;
            mInstr   <= 32'h0;
            mInstrPc <= 32'h0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            mMisalign <= 1'b0;
`endif
        end else begin
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            mMisalign <= 1'b0;
`endif
            case (mState)
                2'd0: mState <= 2'd1;
                2'd1: begin
                    if (bus.imem_ack) begin
                        if (mExcPend || bus.exception) begin
                            mExcPend <= 1'b0;
                        end else begin
                            mInstr   <= bus.imem_rdata;
                            mInstrPc <= bus.pc_curr;
                            mValid   <= 1'b1;
                            mState   <= 2'd2;
                        end
                    end else if (bus.exception) begin
                        mExcPend <= 1'b1;
                    end
                end
                2'd2: begin
                    if (bus.exception || !bus.stall) begin
                        mValid <= 1'b0;
                        mState <= 2'd1;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
                        mMisalign <= !bus.exception && redirMisaligned();
`endif
                    end
                end
                default: mState <= 2'd0;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared = nCompared + 1;
        if (actual !== expected) begin
            nMismatched = nMismatched + 1;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (checkEn) begin
            checkOutput("cyc_state", {30'd0, fsmState}, {30'd0, mState});
            checkOutput("cyc_req", {31'd0, bus.imem_req}, {31'd0, mState == 2'd1});
            checkOutput("cyc_pc_next", bus.pc_next, modelPcNext());
            checkOutput("cyc_valid", {31'd0, bus.instr_valid}, {31'd0, mValid});
            if (mState == 2'd1) checkOutput("cyc_addr", bus.imem_addr, bus.pc_curr);
            if (mValid) begin
                checkOutput("cyc_instr", bus.instr, mInstr);
                checkOutput("cyc_instr_pc", bus.instr_pc, mInstrPc);
            end
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            checkOutput("cyc_misalign", {31'd0, misalign}, {31'd0, mMisalign});
`endif
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic st, input logic jp, input logic [31:0] jt,
                                 input logic br, input logic [31:0] bt, input logic ex);
        bus.stall         = st;
        bus.jump          = jp;
        bus.jump_target   = jt;
        bus.branch_taken  = br;
        bus.branch_target = bt;
        bus.exception     = ex;
    endtask

    task automatic waitState(input logic [1:0] s, input int budget);
        int n;
        n = 0;
        while (fsmState != s && n < budget) begin
            stepCycle();
            n = n + 1;
        end
        checkOutput("wait_state", {30'd0, fsmState}, {30'd0, s});
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1 reset = 1'b0;
        checkEn = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("rst_state", {30'd0, fsmState}, 32'd0);
        checkOutput("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        checkOutput("rst_instr", bus.instr, 32'h0);
        checkOutput("rst_instr_pc", bus.instr_pc, 32'h0);
        checkOutput("rst_req", {31'd0, bus.imem_req}, 32'd0);
        checkOutput("rst_pc_next", bus.pc_next, 32'h0);
        reset = 1'b1;

        // First fetch from the reset vector.
        waitState(2'd2, 30);
        checkOutput("first_instr", bus.instr, 32'h2002_0005);
        checkOutput("first_instr_pc", bus.instr_pc, 32'h0);
        checkOutput("first_valid", {31'd0, bus.instr_valid}, 32'd1);
        checkOutput("first_pc_curr", pcReg, 32'h4);

        // Jump beats branch on the same consume.
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("jump_addr", bus.imem_addr, 32'h40);
        checkOutput("jump_req", {31'd0, bus.imem_req}, 32'd1);

        // Stall holds the word and ignores the branch.
        waitState(2'd2, 30);
        checkOutput("jump_instr_pc", bus.instr_pc, 32'h40);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
            checkOutput("stall_req", {31'd0, bus.imem_req}, 32'd0);
            checkOutput("stall_pc", pcReg, 32'h44);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("release_addr", bus.imem_addr, 32'h44);

        // Exception while waiting: the returning word is dropped.
        waitState(2'd2, 30);
        ackDelay       = 3;
        dataOverrideEn = 1'b1;
        dataOverride   = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("exc_fetch_addr", bus.imem_addr, 32'h48);
        stepCycle();
        bus.exception = 1'b1;
        stepCycle();
        bus.exception = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            checkOutput("exc_no_valid", {31'd0, bus.instr_valid}, 32'd0);
            if (bus.imem_addr == EXC_VEC) break;
        end
        checkOutput("exc_addr", bus.imem_addr, 32'h80);
        dataOverrideEn = 1'b0;
        ackDelay       = 2;
        waitState(2'd2, 30);
        checkOutput("exc_instr_pc", bus.instr_pc, 32'h80);

        // Sequential increment wraps at the top of the address space.
        pcForce    = 1'b1;
        pcForceVal = 32'hFFFF_FFFC;
        stepCycle();
        pcForce = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("wrap_fetch_addr", bus.imem_addr, 32'hFFFF_FFFC);
        waitState(2'd2, 30);
        checkOutput("wrap_instr_pc", bus.instr_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_pc_curr", pcReg, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("wrap_addr", bus.imem_addr, 32'h0);

        // Misaligned branch target.
        waitState(2'd2, 30);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h102, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        checkOutput("misalign_addr", bus.imem_addr, 32'h80);
        checkOutput("misalign_pulse", {31'd0, misalign}, 32'd1);
        stepCycle();
        checkOutput("misalign_clear", {31'd0, misalign}, 32'd0);
`else
        checkOutput("misalign_addr", bus.imem_addr, 32'h100);
`endif

        // Exception during a stall still redirects.
        waitState(2'd2, 30);
        bus.exception = 1'b1;
        stepCycle();
        bus.exception = 1'b0;
        checkOutput("exc_stall_state", {30'd0, fsmState}, 32'd1);
        checkOutput("exc_stall_valid", {31'd0, bus.instr_valid}, 32'd0);
        checkOutput("exc_stall_addr", bus.imem_addr, 32'h80);

        // Reset in the middle of an outstanding request.
        stepCycle();
        reset = 1'b0;
        #1;
        checkOutput("midrst_state", {30'd0, fsmState}, 32'd0);
        checkOutput("midrst_req", {31'd0, bus.imem_req}, 32'd0);
        stepCycle();
        reset = 1'b1;
        waitState(2'd2, 30);
        checkOutput("midrst_instr_pc", bus.instr_pc, 32'h0);
        checkOutput("midrst_instr", bus.instr, 32'h2002_0005);

        stepCycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Fetch controller that sequences the program-counter register.
- Drives the PC register's next-value input every cycle and runs a req/ack handshake to instruction memory.
- Presents fetched instructions to decode with a valid/stall handshake.
- Applies branch, jump and exception redirects with fixed priority.
- Sits between the PC register, the instruction memory port and the decode stage.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- EXC_VECTOR, 32'h0000_0080, redirect address on exception.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pc_curr  in  32  current PC register output
- pc_next  out  32  next PC; PC register loads it every clock
- imem_req  out  1  instruction memory request
- imem_addr  out  32  request address
- imem_ack  in  1  memory accepted request; rdata valid this cycle
- imem_rdata  in  32  instruction word
- instr  out  32  registered instruction to decode
- instr_pc  out  32  address of instr
- instr_valid  out  1  instr valid for decode
- stall  in  1  decode not ready; instr must be held
- branch_taken  in  1  redirect to branch_target (qualified by consume)
- branch_target  in  32
- jump  in  1  redirect to jump_target (qualified by consume)
- jump_target  in  32
- exception  in  1  redirect to EXC_VECTOR, any state
- fsm_state  out  2  current state, for debug

Behaviour:
- States: BOOT=0, FETCH=1, ISSUE=2.
- Reset (async, reset=0): state=BOOT; instr=0; instr_pc=0; instr_valid=0; exc_pending=0. Combinational outputs in BOOT: imem_req=0, pc_next=RESET_VECTOR.
- Reset asserted mid-transaction: outstanding request abandoned, no ack tracking survives.
- BOOT: one cycle, pc_next=RESET_VECTOR, then FETCH. This holds even though the PC register resets to 0.
- FETCH, request phase:
  - imem_req=1, imem_addr=pc_curr.
  - pc_next=pc_curr while waiting, so the PC holds.
  - imem_req stays high with a stable address until imem_ack; the request is never withdrawn.
- FETCH, ack with exc_pending=0: instr<=imem_rdata, instr_pc<=pc_curr, instr_valid<=1, pc_next=pc_curr+PC_STEP, go ISSUE.
- FETCH, exception while waiting for ack: set exc_pending. On the ack cycle, discard rdata, pc_next=EXC_VECTOR, clear exc_pending, stay FETCH.
- FETCH, exception and ack in the same cycle: treated as exc_pending=1 (data discarded).
- ISSUE, stall=1: instr, instr_pc and instr_valid held; pc_next=pc_curr; imem_req=0. branch_taken and jump are ignored.
- ISSUE, stall=0 (consume): instr_valid<=0, go FETCH. pc_next selection:
  - exception -> EXC_VECTOR
  - else jump -> jump_target
  - else branch_taken -> branch_target
  - else pc_curr (already advanced)
- ISSUE, exception with stall=1: redirect anyway. pc_next=EXC_VECTOR, instr_valid<=0, go FETCH.
- Latency: one instruction per ack+1 cycles minimum; instr_valid rises the cycle after ack.
- Arithmetic: 32-bit adds wrap modulo 2^32; 32'hFFFF_FFFC+4 -> 0.
- Never more than one outstanding request.

Optional Feature:
- PC_FETCH_MISALIGN_TRAP_EN defined:
  - A jump or branch target with bits[1:0]!=0 is replaced by EXC_VECTOR.
  - Extra output misalign (1 bit, registered, reset 0) pulses for one cycle.
- Undefined: target bits[1:0] forced to 0; no misalign port.

Decomposition:
- Package pc_fetch_pkg: state enum (BOOT/FETCH/ISSUE, 2 bits), default RESET_VECTOR/EXC_VECTOR/PC_STEP constants, redirect-select enum (SEQ/BRANCH/JUMP/EXC).
- Sub-module pc_redirect_mux: combinational priority select of pc_next from the redirect-select enum, including the optional misalign check.

Test Plan:
- Release reset; memory acks after 2 cycles with 32'h2002_0005 -> one cycle with pc_next=0, imem_addr=0; then instr=32'h2002_0005, instr_pc=0, instr_valid=1; pc_curr becomes 4.
- Consume with jump=1, jump_target=32'h0000_0040, branch_taken=1 the same cycle -> next imem_addr=32'h40 (jump beats branch).
- Hold stall=1 for 5 cycles in ISSUE with branch_taken=1 -> instr_valid stays 1, pc_curr stable, imem_req=0, branch ignored; release -> sequential fetch at pc_curr.
- Assert exception during a FETCH wait, ack 3 cycles later with 32'hDEAD_BEEF -> instr_valid never rises for that word; next imem_addr=32'h80.
- Set pc_curr path to 32'hFFFF_FFFC and fetch -> following imem_addr=0.
- With PC_FETCH_MISALIGN_TRAP_EN defined, branch_target=32'h0000_0102 -> misalign pulses, next imem_addr=32'h80. Without the macro -> next imem_addr=32'h100.
